mpmc11_burst_ctrl: RTL and testbench

Per-transaction sequencer for the mpmc11 memory port. It accepts one granted burst request (read or write) from the upstream port arbiter and walks the mpmc11_state_t sequence. It drives the MIG-style app_* command, write-data and read-data handshakes and counts beats. It instantiates the address generator so that app_addr advances in lockstep with accepted commands.

---
 rtl/mpmc11_pkg.sv | 18 +
 rtl/mpmc11_addr_gen.sv | 46 ++++
 rtl/mpmc11_burst_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mpmc11_burst_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpmc11_pkg.sv
// Shared types and command encodings for the mpmc11 memory port sequencer.
package mpmc11_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESET1     = 3'd1,
    PRESET2     = 3'd2,
    READ_DATA0  = 3'd3,
    READ_DATA1  = 3'd4,
    WRITE_DATA0 = 3'd5,
    WRITE_DATA1 = 3'd6,
    ACK         = 3'd7
  } mpmc11_state_t;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

endpackage

// File: rtl/mpmc11_addr_gen.sv
// Beat address generator: loads the aligned base in PRESET2 and steps by one
// beat on every accepted command except the last, so app_addr names the beat in flight.
module mpmc11_addr_gen
  import mpmc11_pkg::*;
#(
  parameter int WID = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  mpmc11_state_t state_i,
  input  logic          rdy_i,
  input  logic          wdf_rdy_i,
  input  logic [7:0]    burst_len_i,
  input  logic [7:0]    burst_cnt_i,
  input  logic [29:5]   addr_base_i,
  output logic [31:0]   app_addr_o
);

  localparam logic [29:0] INC_AMT = 30'(WID / 8);

  logic [31:0] addr_q, addr_d;
  logic        more_beats;

  assign more_beats = (burst_cnt_i != burst_len_i);

  // Bits 31:30 are never loaded or carried into, so they stay zero.
  always_comb begin
    addr_d = addr_q;
    case (state_i)
      PRESET2:     addr_d = {2'b00, addr_base_i, 5'h0};
      READ_DATA0:  if (rdy_i && more_beats)
                     addr_d = {2'b00, addr_q[29:0] + INC_AMT};
      WRITE_DATA1: if (rdy_i && wdf_rdy_i && more_beats)
                     addr_d = {2'b00, addr_q[29:0] + INC_AMT};
      default:     addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign app_addr_o = addr_q;

endmodule

// File: rtl/mpmc11_burst_ctrl.sv
// Per-transaction burst sequencer for the mpmc11 port: takes one granted request
// and drives the app_* command / write-data / read-data handshakes beat by beat.
module mpmc11_burst_ctrl
  import mpmc11_pkg::*;
#(
  parameter int WID = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr_base_i,
  input  logic [7:0]       burst_len_i,
  input  logic [WID-1:0]   wdata,
  input  logic [WID/8-1:0] wbe,
  input  logic             wvalid,
  output logic             wready,
  output logic [WID-1:0]   rdata,
  output logic             rvalid,
  output logic             rlast,
  output logic             busy,
  output logic             done,
  output mpmc11_state_t    state,
  output logic [7:0]       burst_cnt,
  output logic             app_en,
  output logic [2:0]       app_cmd,
  output logic [31:0]      app_addr,
  input  logic             app_rdy,
  output logic [WID-1:0]   app_wdf_data,
  output logic [WID/8-1:0] app_wdf_mask,
  output logic             app_wdf_wren,
  output logic             app_wdf_end,
  input  logic             app_wdf_rdy,
  input  logic [WID-1:0]   app_rd_data,
  input  logic             app_rd_data_valid
);

  // Handshakes: a beat/command transfers on a clock edge where its valid and
  // ready are both high; once valid is raised its payload holds until then.
  mpmc11_state_t    state_q, state_d;
  logic             we_q, we_d;
  logic [29:5]      base_q, base_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [7:0]       rd_cnt_q, rd_cnt_d;
  logic [WID-1:0]   wdata_q, wdata_d;
  logic [WID/8-1:0] wmask_q, wmask_d;
  logic             rd_beat, rd_last;
  logic             addr_bits_unused;

  // Only the beat-aligned, 30-bit reachable part of the base is meaningful.
  assign addr_bits_unused = ^{addr_base_i[31:30], addr_base_i[4:0]};

  assign rd_beat = ((state_q == READ_DATA0) || (state_q == READ_DATA1)) && app_rd_data_valid;
  assign rd_last = rd_beat && (rd_cnt_q == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      burst_cnt_q <= '0;
      rd_cnt_q    <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      base_q      <= base_d;
      len_q       <= len_d;
      burst_cnt_q <= burst_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    base_d      = base_q;
    len_d       = len_q;
    burst_cnt_d = burst_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        base_d  = addr_base_i[29:5];
        len_d   = burst_len_i;
        state_d = PRESET1;
      end
      PRESET1: begin
        burst_cnt_d = '0;
        rd_cnt_d    = '0;
        state_d     = PRESET2;
      end
      PRESET2: state_d = we_q ? WRITE_DATA0 : READ_DATA0;
      READ_DATA0: if (app_rdy) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
        if (burst_cnt_q == len_q) state_d = READ_DATA1;
      end
      READ_DATA1: state_d = READ_DATA1;
      WRITE_DATA0: if (wvalid) begin
        wdata_d = wdata;
        wmask_d = ~wbe;
        state_d = WRITE_DATA1;
      end
      WRITE_DATA1: if (app_rdy && app_wdf_rdy) begin
        burst_cnt_d = burst_cnt_q + 8'd1;
        state_d     = (burst_cnt_q == len_q) ? ACK : WRITE_DATA0;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The final read beat wins even when it lands alongside the final command.
    if (rd_beat) rd_cnt_d = rd_cnt_q + 8'd1;
    if (rd_last) state_d = ACK;
  end

  always_comb begin
    wready       = 1'b0;
    app_en       = 1'b0;
    app_cmd      = '0;
    app_wdf_data = '0;
    app_wdf_mask = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    busy         = (state_q != IDLE);
    done         = (state_q == ACK);
    rvalid       = rd_beat;
    rlast        = rd_last;
    rdata        = rd_beat ? app_rd_data : '0;
    case (state_q)
      READ_DATA0: begin
        app_en  = 1'b1;
        app_cmd = CMD_READ;
      end
      WRITE_DATA0: wready = wvalid;
      WRITE_DATA1: begin
        app_en       = 1'b1;
        app_cmd      = CMD_WRITE;
        app_wdf_data = wdata_q;
        app_wdf_mask = wmask_q;
        app_wdf_wren = 1'b1;
        app_wdf_end  = 1'b1;
      end
      default: app_en = 1'b0;
    endcase
  end

  assign state     = state_q;
  assign burst_cnt = burst_cnt_q;

  mpmc11_addr_gen #(.WID(WID)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .state_i     (state_q),
    .rdy_i       (app_rdy),
    .wdf_rdy_i   (app_wdf_rdy),
    .burst_len_i (len_q),
    .burst_cnt_i (burst_cnt_q),
    .addr_base_i (base_q),
    .app_addr_o  (app_addr)
  );

endmodule

// File: tb/tb_mpmc11_burst_ctrl.sv
// Directed bench for mpmc11_burst_ctrl: a read-return memory model, a write-beat
// driver and a scoreboard of expected commands and read beats.
module tb_mpmc11_burst_ctrl;
  import mpmc11_pkg::*;

  localparam int WID = 256;

  typedef struct packed {
    logic [2:0]       cmd;
    logic [31:0]      addr;
    logic [WID-1:0]   data;
    logic [WID/8-1:0] mask;
  } cmd_t;

  typedef struct {
    int          due;
    logic [31:0] a;
  } pend_t;

  logic             clk, rst, req, we;
  logic [31:0]      addr_base_i;
  logic [7:0]       burst_len_i;
  logic [WID-1:0]   wdata;
  logic [WID/8-1:0] wbe;
  logic             wvalid, wready;
  logic [WID-1:0]   rdata;
  logic             rvalid, rlast, busy, done;
  mpmc11_state_t    state;
  logic [7:0]       burst_cnt;
  logic             app_en;
  logic [2:0]       app_cmd;
  logic [31:0]      app_addr;
  logic             app_rdy;
  logic [WID-1:0]   app_wdf_data;
  logic [WID/8-1:0] app_wdf_mask;
  logic             app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [WID-1:0]   app_rd_data;
  logic             app_rd_data_valid;

  logic           rdy_toggle, rdy_val, tick;
  logic           rsp_valid, stray_valid;
  logic [WID-1:0] rsp_data;
  logic           wv_gate;
  logic [7:0]     w_tag;
  int             w_len, w_beat, cyc;
  int             n_cmp, n_err, done_cnt, max_cnt;

  cmd_t           exp_cmd_q[$];
  logic [WID:0]   exp_q[$];
  pend_t          pend_q[$];

  assign app_rdy           = rdy_toggle ? tick : rdy_val;
  assign app_rd_data_valid = rsp_valid | stray_valid;
  assign app_rd_data       = rsp_data;

  mpmc11_burst_ctrl #(.WID(WID)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr_base_i(addr_base_i), .burst_len_i(burst_len_i),
    .wdata(wdata), .wbe(wbe), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .busy(busy), .done(done),
    .state(state), .burst_cnt(burst_cnt),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / model ----------------
  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int i);
    logic [29:0] a;
    a = {base[29:5], 5'h0} + 30'(i * 32);
    return {2'b00, a};
  endfunction

  function automatic logic [WID-1:0] rd_pat(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [WID-1:0] wd(input logic [7:0] tag, input int i);
    return {8{tag, 24'(i)}};
  endfunction

  function automatic logic [WID/8-1:0] wb(input logic [7:0] tag, input int i);
    return 32'h0F0F_33CC ^ {4{tag}} ^ 32'(i);
  endfunction

  task automatic push_read(input logic [31:0] base, input int len);
    for (int i = 0; i <= len; i++) begin
      exp_cmd_q.push_back('{CMD_READ, exp_addr(base, i), '0, '0});
      exp_q.push_back({(i == len), rd_pat(exp_addr(base, i))});
    end
  endtask

  task automatic push_write(input logic [31:0] base, input int len, input logic [7:0] tag);
    for (int i = 0; i <= len; i++)
      exp_cmd_q.push_back('{CMD_WRITE, exp_addr(base, i), wd(tag, i), ~wb(tag, i)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_txn(input logic w, input logic [31:0] base, input logic [7:0] len,
                           input bit hold);
    @(posedge clk); #1;
    req = 1'b1; we = w; addr_base_i = base; burst_len_i = len;
    @(negedge clk); chk("st_idle", state, IDLE);
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
    @(negedge clk); chk("st_preset1", state, PRESET1);
    @(negedge clk); chk("st_preset2", state, PRESET2);
    @(negedge clk); chk("st_data0", state, w ? WRITE_DATA0 : READ_DATA0);
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start_cnt;
    int n;
    start_cnt = done_cnt;
    n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, done_cnt - start_cnt, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, state, IDLE);
    chk({tag, "_flags"}, {wready, rvalid, rlast, busy, done, app_en, app_wdf_wren, app_wdf_end}, 8'h00);
    chk({tag, "_cnt"}, burst_cnt, 8'h00);
    chk({tag, "_addr"}, app_addr, 32'h0);
    chk({tag, "_cmd"}, app_cmd, 3'b000);
    chk({tag, "_wdf"}, app_wdf_data, '0);
    chk({tag, "_mask"}, app_wdf_mask, '0);
    chk({tag, "_rdata"}, rdata, '0);
  endtask

  // app_rdy toggle source
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick = ~tick;
    end
  end

  // Read-return memory: each accepted read returns rd_pat(addr) 5 cycles later.
  initial begin
    rsp_valid = 1'b0;
    rsp_data  = '0;
    cyc       = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = rd_pat(pend_q[0].a);
        void'(pend_q.pop_front());
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
      end
      @(negedge clk);
      if (app_en && app_rdy && app_cmd == CMD_READ) pend_q.push_back('{cyc + 5, app_addr});
    end
  end

  // Requester write-beat source
  initial begin
    logic took;
    wvalid = 1'b0;
    wdata  = '0;
    wbe    = '0;
    w_beat = 0;
    forever begin
      @(negedge clk);
      took = wvalid && wready;
      @(posedge clk); #2;
      if (state == PRESET1) w_beat = 0;
      else if (took)        w_beat++;
      wvalid = wv_gate && (w_beat <= w_len);
      wdata  = wd(w_tag, w_beat);
      wbe    = wb(w_tag, w_beat);
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    cmd_t         f;
    logic [WID:0] e;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (int'(burst_cnt) > max_cnt) max_cnt = int'(burst_cnt);
      if (rvalid) begin
        if (exp_q.size() == 0) chk("rd_extra", rvalid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", rdata, e[WID-1:0]);
          chk("rlast", rlast, e[WID]);
        end
      end
      if (app_en) begin
        if (exp_cmd_q.size() == 0) chk("cmd_extra", app_en, 1'b0);
        else begin
          f = exp_cmd_q[0];
          chk("app_cmd", app_cmd, f.cmd);
          chk("app_addr", app_addr, f.addr);
          chk("app_wdf_data", app_wdf_data, f.data);
          chk("app_wdf_mask", app_wdf_mask, f.mask);
          chk("app_wdf_wren", app_wdf_wren, (f.cmd == CMD_WRITE));
          chk("app_wdf_end", app_wdf_end, (f.cmd == CMD_WRITE));
          if (app_rdy && (f.cmd == CMD_READ || app_wdf_rdy)) void'(exp_cmd_q.pop_front());
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    n_cmp = 0; n_err = 0; max_cnt = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr_base_i = '0; burst_len_i = '0;
    rdy_toggle = 1'b0; rdy_val = 1'b1; app_wdf_rdy = 1'b1;
    stray_valid = 1'b0; wv_gate = 1'b0; w_len = 0; w_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // 4-beat read, data returned 5 cycles after each command
    push_read(32'h1234_5678, 3);
    start_txn(1'b0, 32'h1234_5678, 8'd3, 1'b0);
    wait_done(100, "rd4_done");
    chk("rd4_cmd_left", exp_cmd_q.size(), 0);
    chk("rd4_beats_left", exp_q.size(), 0);

    // 2-beat write, write-data path stalled on the first beat
    w_len = 1; w_tag = 8'h31; wv_gate = 1'b1; app_wdf_rdy = 1'b0;
    push_write(32'h0000_2004, 1, 8'h31);
    start_txn(1'b1, 32'h0000_2004, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_stall_state", state, WRITE_DATA1);
      chk("wr_stall_cnt", burst_cnt, 8'd0);
    end
    @(posedge clk); #1;
    app_wdf_rdy = 1'b1;
    wait_done(50, "wr2_done");
    chk("wr2_cmd_left", exp_cmd_q.size(), 0);

    // 1-beat write with requester data late by 4 cycles
    wv_gate = 1'b0; w_len = 0; w_tag = 8'hC4;
    push_write(32'h0000_0ABC, 0, 8'hC4);
    start_txn(1'b1, 32'h0000_0ABC, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_wait_state", state, WRITE_DATA0);
      chk("wr_wait_en", {app_en, wready}, 2'b00);
    end
    @(posedge clk); #1;
    wv_gate = 1'b1;
    @(negedge clk);
    chk("wr_late_wready", wready, 1'b1);
    wait_done(20, "wr1_done");
    chk("wr1_cmd_left", exp_cmd_q.size(), 0);
    wv_gate = 1'b0;

    // stray read data while idle must not surface
    @(posedge clk); #1;
    stray_valid = 1'b1;
    @(negedge clk);
    chk("idle_stray_rvalid", rvalid, 1'b0);
    @(posedge clk); #1;
    stray_valid = 1'b0;

    // 256-beat read with app_rdy toggling
    rdy_toggle = 1'b1; max_cnt = 0;
    push_read(32'h0000_1000, 255);
    start_txn(1'b0, 32'h0000_1000, 8'd255, 1'b0);
    wait_done(2000, "rd256_done");
    chk("rd256_maxcnt", max_cnt, 255);
    chk("rd256_cmd_left", exp_cmd_q.size(), 0);
    chk("rd256_beats_left", exp_q.size(), 0);
    rdy_toggle = 1'b0;

    // reset while a write beat is stalled in WRITE_DATA1
    w_len = 3; w_tag = 8'h77; wv_gate = 1'b1; app_wdf_rdy = 1'b0;
    push_write(32'h0000_3000, 3, 8'h77);
    start_txn(1'b1, 32'h0000_3000, 8'd3, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_pre_state", state, WRITE_DATA1);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0; wv_gate = 1'b0; app_wdf_rdy = 1'b1;
    exp_cmd_q.delete();
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt, d0);
    push_read(32'h0000_0100, 1);
    start_txn(1'b0, 32'h0000_0100, 8'd1, 1'b0);
    wait_done(50, "rst_fresh_done");
    chk("rst_fresh_left", exp_cmd_q.size() + exp_q.size(), 0);

    // req held high (with changing inputs) during a 1-beat read at a high base
    push_read(32'hC000_0047, 0);
    start_txn(1'b0, 32'hC000_0047, 8'd0, 1'b1);
    @(posedge clk); #1;
    we = 1'b1; addr_base_i = 32'h0000_7777; burst_len_i = 8'd9;
    wait_done(50, "busy_req_done");
    #1;
    req = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("busy_req_idle", busy, 1'b0);
    chk("busy_req_no_done", done_cnt, d0);
    chk("busy_req_left", exp_cmd_q.size() + exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
